dbus_buffer: RTL and testbench

DBUS_BUFFER -- requirements
Module: dbus_buffer

---
 rtl/dbus_buffer_if.sv | 32 +++
 rtl/dbus_buffer.sv | 111 +++++++++++
 tb/tb_dbus_buffer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_buffer_if.sv
// Data-bus request/response types and the handshake interface that carries them.
// master drives req and reads resp; slave reads req and drives resp.
package dbus_pkg;
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

interface dbus_buffer_if;
  dbus_pkg::dbus_req_t  req;
  dbus_pkg::dbus_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/dbus_buffer.sv
// Decouples the memory stage from the data bus. A request is held stable on the bus until it
// completes, even if M stalls or is squashed.
//   state   | meaning
//   IDLE    | no outstanding access, mreq passes straight to dreq
//   REQ     | latched request outstanding, result wanted by M
//   DONE    | result captured, waiting for M to advance
//   DRAIN   | latched request outstanding, result will be discarded
module dbus_buffer
  import dbus_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  dbus_buffer_if.slave  m,
  dbus_buffer_if.master d,
  input  logic          adv,
  input  logic          flush,
  output logic          busy,
  output logic [31:0]   wait_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  dbus_req_t   req_q, req_d, dreq_c;
  logic [63:0] data_q, data_d, resp_data;
  logic        resp_ok;
  logic [31:0] wait_cnt_q;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    data_d    = data_q;
    dreq_c    = '0;
    resp_ok   = 1'b0;
    resp_data = '0;
    case (state_q)
      S_IDLE: begin
        dreq_c       = m.req;
        dreq_c.valid = m.req.valid & ~flush;
        if (dreq_c.valid) begin
          if (d.resp.data_ok) begin
            resp_ok   = 1'b1;
            resp_data = d.resp.data;
            if (!adv) begin
              state_d = S_DONE;
              data_d  = d.resp.data;
            end
          end else begin
            req_d   = dreq_c;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        dreq_c       = req_q;
        dreq_c.valid = 1'b1;
        if (flush) begin
          state_d = d.resp.data_ok ? S_IDLE : S_DRAIN;
        end else if (d.resp.data_ok) begin
          resp_ok   = 1'b1;
          resp_data = d.resp.data;
          if (adv) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            data_d  = d.resp.data;
          end
        end
      end
      S_DRAIN: begin
        dreq_c       = req_q;
        dreq_c.valid = 1'b1;
        if (d.resp.data_ok) state_d = S_IDLE;
      end
      default: begin
        resp_ok   = 1'b1;
        resp_data = data_q;
        if (adv || flush) state_d = S_IDLE;
      end
    endcase
    // A reset cycle abandons whatever is in flight, so nothing may be issued or reported.
    if (reset) begin
      dreq_c.valid = 1'b0;
      resp_ok      = 1'b0;
      resp_data    = '0;
    end
  end

  assign d.req    = dreq_c;
  assign m.resp   = '{addr_ok: dreq_c.valid & d.resp.addr_ok, data_ok: resp_ok, data: resp_data};
  assign busy     = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign wait_cnt = wait_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      data_q     <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      if (busy && (wait_cnt_q != 32'hFFFF_FFFF)) wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_dbus_buffer.sv
// Directed bench for dbus_buffer: pass-through, stalls, flushes, reset and counter saturation.
module tb_dbus_buffer;
  import dbus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        adv;
  logic        flush;
  logic        busy;
  logic [31:0] wait_cnt;
  int          total = 0;
  int          bad = 0;

  dbus_buffer_if mbus ();
  dbus_buffer_if dbus ();

  dbus_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .m        (mbus),
    .d        (dbus),
    .adv      (adv),
    .flush    (flush),
    .busy     (busy),
    .wait_cnt (wait_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] T_IDLE = 2'd0, T_REQ = 2'd1, T_DONE = 2'd2, T_DRAIN = 2'd3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mbus.req  = '0;
    dbus.resp = '0;
    adv       = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    mbus.req.valid = 1'b1;
    mbus.req.addr = 64'h40;
    dbus.resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h55};
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (dbus.req.valid !== 1'b0) begin bad++; $display("FAIL rst_dreq_valid: got %0b want 0", dbus.req.valid); end
    total++; if (mbus.resp.data_ok !== 1'b0) begin bad++; $display("FAIL rst_data_ok: got %0b want 0", mbus.resp.data_ok); end
    total++; if (mbus.resp.addr_ok !== 1'b0) begin bad++; $display("FAIL rst_addr_ok: got %0b want 0", mbus.resp.addr_ok); end
    reset = 1'b0;
    idle_inputs();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    total++; if (wait_cnt !== 32'd0) begin bad++; $display("FAIL rst_wait_cnt: got %h want 0", wait_cnt); end
    total++; if (dut.state_q !== T_IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", dut.state_q, T_IDLE); end
    total++; if (mbus.resp.data !== 64'd0) begin bad++; $display("FAIL rst_resp_data: got %h want 0", mbus.resp.data); end
  endtask

  task automatic test_hit();
    tick();
    mbus.req = '{valid: 1'b1, addr: 64'h8000_0010, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    dbus.resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h1122334455667788};
    adv = 1'b1;
    #1;
    total++; if (dbus.req.valid !== 1'b1) begin bad++; $display("FAIL hit_dreq_valid: got %0b want 1", dbus.req.valid); end
    total++; if (dbus.req.addr !== 64'h8000_0010) begin bad++; $display("FAIL hit_dreq_addr: got %h want 80000010", dbus.req.addr); end
    total++; if (mbus.resp.data_ok !== 1'b1) begin bad++; $display("FAIL hit_data_ok: got %0b want 1", mbus.resp.data_ok); end
    total++; if (mbus.resp.data !== 64'h1122334455667788) begin bad++; $display("FAIL hit_data: got %h want 1122334455667788", mbus.resp.data); end
    total++; if (mbus.resp.addr_ok !== 1'b1) begin bad++; $display("FAIL hit_addr_ok: got %0b want 1", mbus.resp.addr_ok); end
    tick();
    idle_inputs();
    #1;
    total++; if (dut.state_q !== T_IDLE) begin bad++; $display("FAIL hit_state: got %0d want %0d", dut.state_q, T_IDLE); end
    total++; if (wait_cnt !== 32'd0) begin bad++; $display("FAIL hit_wait_cnt: got %h want 0", wait_cnt); end
    total++; if (mbus.resp.data_ok !== 1'b0) begin bad++; $display("FAIL hit_after_data_ok: got %0b want 0", mbus.resp.data_ok); end
  endtask

  task automatic test_hit_stall();
    tick();
    mbus.req = '{valid: 1'b1, addr: 64'h20, size: MSIZE4, strobe: 8'h00, data: 64'h0};
    dbus.resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hCAFE_F00D_0000_0001};
    adv = 1'b0;
    #1;
    total++; if (mbus.resp.data_ok !== 1'b1) begin bad++; $display("FAIL stall_data_ok: got %0b want 1", mbus.resp.data_ok); end
    tick();
    mbus.req.addr = 64'h28;
    dbus.resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hBAD0_BAD0_BAD0_BAD0};
    #1;
    total++; if (dut.state_q !== T_DONE) begin bad++; $display("FAIL stall_state: got %0d want %0d", dut.state_q, T_DONE); end
    total++; if (dbus.req.valid !== 1'b0) begin bad++; $display("FAIL stall_done_dreq_valid: got %0b want 0", dbus.req.valid); end
    total++; if (mbus.resp.data_ok !== 1'b1) begin bad++; $display("FAIL stall_done_data_ok: got %0b want 1", mbus.resp.data_ok); end
    total++; if (mbus.resp.data !== 64'hCAFE_F00D_0000_0001) begin bad++; $display("FAIL stall_done_data: got %h want cafef00d00000001", mbus.resp.data); end
    total++; if (mbus.resp.addr_ok !== 1'b0) begin bad++; $display("FAIL stall_done_addr_ok: got %0b want 0", mbus.resp.addr_ok); end
    tick();
    mbus.req.valid = 1'b0;
    adv = 1'b1;
    #1;
    total++; if (mbus.resp.data !== 64'hCAFE_F00D_0000_0001) begin bad++; $display("FAIL stall_hold_data: got %h want cafef00d00000001", mbus.resp.data); end
    tick();
    idle_inputs();
    #1;
    total++; if (dut.state_q !== T_IDLE) begin bad++; $display("FAIL stall_exit_state: got %0d want %0d", dut.state_q, T_IDLE); end
    total++; if (mbus.resp.data_ok !== 1'b0) begin bad++; $display("FAIL stall_exit_data_ok: got %0b want 0", mbus.resp.data_ok); end
    total++; if (mbus.resp.data !== 64'd0) begin bad++; $display("FAIL stall_exit_data: got %h want 0", mbus.resp.data); end
  endtask

  task automatic test_store();
    dbus_req_t st;
    st = '{valid: 1'b1, addr: 64'h0000_1000, size: MSIZE4, strobe: 8'h0F, data: 64'hDEAD_BEEF_0123_4567};
    mbus.req = st;
    dbus.resp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 64'h0};
    #1;
    total++; if (dbus.req !== st) begin bad++; $display("FAIL store_issue: got %h want %h", dbus.req, st); end
    total++; if (mbus.resp.data_ok !== 1'b0) begin bad++; $display("FAIL store_issue_data_ok: got %0b want 0", mbus.resp.data_ok); end
    for (int i = 0; i < 3; i++) begin
      tick();
      mbus.req = '{valid: 1'b1, addr: 64'h9999_0000, size: MSIZE1, strobe: 8'h01, data: 64'h1};
      dbus.resp = '{addr_ok: 1'b1, data_ok: (i == 2), data: 64'h0000_0000_0000_5A5A};
      #1;
      total++; if (dbus.req !== st) begin bad++; $display("FAIL store_stable_%0d: got %h want %h", i, dbus.req, st); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL store_busy_%0d: got %0b want 1", i, busy); end
      total++; if (mbus.resp.data_ok !== (i == 2)) begin bad++; $display("FAIL store_data_ok_%0d: got %0b want %0b", i, mbus.resp.data_ok, (i == 2)); end
    end
    total++; if (mbus.resp.data !== 64'h5A5A) begin bad++; $display("FAIL store_resp_data: got %h want 5a5a", mbus.resp.data); end
    tick();
    idle_inputs();
    adv = 1'b1;
    #1;
    total++; if (dut.state_q !== T_DONE) begin bad++; $display("FAIL store_done_state: got %0d want %0d", dut.state_q, T_DONE); end
    total++; if (mbus.resp.data !== 64'h5A5A) begin bad++; $display("FAIL store_done_data: got %h want 5a5a", mbus.resp.data); end
    total++; if (wait_cnt !== 32'd3) begin bad++; $display("FAIL store_wait_cnt: got %0d want 3", wait_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL store_done_busy: got %0b want 0", busy); end
    tick();
    idle_inputs();
    #1;
    total++; if (dut.state_q !== T_IDLE) begin bad++; $display("FAIL store_exit_state: got %0d want %0d", dut.state_q, T_IDLE); end
  endtask

  task automatic test_flush();
    dbus_req_t fl;
    fl = '{valid: 1'b1, addr: 64'h0000_2008, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    mbus.req = fl;
    #1;
    total++; if (dbus.req !== fl) begin bad++; $display("FAIL flush_issue: got %h want %h", dbus.req, fl); end
    tick();
    mbus.req = '{valid: 1'b1, addr: 64'h7777, size: MSIZE2, strobe: 8'h03, data: 64'h7};
    #1;
    total++; if (dut.state_q !== T_REQ) begin bad++; $display("FAIL flush_req_state: got %0d want %0d", dut.state_q, T_REQ); end
    tick();
    flush = 1'b1;
    #1;
    total++; if (mbus.resp.data_ok !== 1'b0) begin bad++; $display("FAIL flush_req2_data_ok: got %0b want 0", mbus.resp.data_ok); end
    total++; if (dbus.req !== fl) begin bad++; $display("FAIL flush_req2_stable: got %h want %h", dbus.req, fl); end
    tick();
    flush = 1'b0;
    #1;
    total++; if (dut.state_q !== T_DRAIN) begin bad++; $display("FAIL flush_drain_state: got %0d want %0d", dut.state_q, T_DRAIN); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_drain_busy: got %0b want 1", busy); end
    total++; if (dbus.req !== fl) begin bad++; $display("FAIL flush_drain_stable: got %h want %h", dbus.req, fl); end
    tick();
    dbus.resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0F0F_0F0F_0F0F_0F0F};
    adv = 1'b1;
    #1;
    total++; if (mbus.resp.data_ok !== 1'b0) begin bad++; $display("FAIL flush_drain_data_ok: got %0b want 0", mbus.resp.data_ok); end
    total++; if (mbus.resp.data !== 64'd0) begin bad++; $display("FAIL flush_drain_data: got %h want 0", mbus.resp.data); end
    total++; if (dbus.req !== fl) begin bad++; $display("FAIL flush_drain_last: got %h want %h", dbus.req, fl); end
    tick();
    idle_inputs();
    #1;
    total++; if (dut.state_q !== T_IDLE) begin bad++; $display("FAIL flush_exit_state: got %0d want %0d", dut.state_q, T_IDLE); end
    total++; if (wait_cnt !== 32'd7) begin bad++; $display("FAIL flush_wait_cnt: got %0d want 7", wait_cnt); end
  endtask

  task automatic test_idle_flush();
    mbus.req = '{valid: 1'b1, addr: 64'h4000, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    dbus.resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h1234};
    flush = 1'b1;
    #1;
    total++; if (dbus.req.valid !== 1'b0) begin bad++; $display("FAIL iflush_dreq_valid: got %0b want 0", dbus.req.valid); end
    total++; if (mbus.resp.data_ok !== 1'b0) begin bad++; $display("FAIL iflush_data_ok: got %0b want 0", mbus.resp.data_ok); end
    total++; if (mbus.resp.addr_ok !== 1'b0) begin bad++; $display("FAIL iflush_addr_ok: got %0b want 0", mbus.resp.addr_ok); end
    tick();
    idle_inputs();
    #1;
    total++; if (dut.state_q !== T_IDLE) begin bad++; $display("FAIL iflush_state: got %0d want %0d", dut.state_q, T_IDLE); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL iflush_busy: got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    mbus.req = '{valid: 1'b1, addr: 64'h5000, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    tick();
    reset = 1'b1;
    mbus.req.addr = 64'h5008;
    dbus.resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hAAAA};
    #1;
    total++; if (dbus.req.valid !== 1'b0) begin bad++; $display("FAIL rmid_dreq_valid: got %0b want 0", dbus.req.valid); end
    total++; if (mbus.resp.data_ok !== 1'b0) begin bad++; $display("FAIL rmid_data_ok: got %0b want 0", mbus.resp.data_ok); end
    tick();
    reset = 1'b0;
    mbus.req = '{valid: 1'b1, addr: 64'h3000, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    dbus.resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hBBBB};
    adv = 1'b1;
    #1;
    total++; if (dut.state_q !== T_IDLE) begin bad++; $display("FAIL rmid_state: got %0d want %0d", dut.state_q, T_IDLE); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %0b want 0", busy); end
    total++; if (wait_cnt !== 32'd0) begin bad++; $display("FAIL rmid_wait_cnt: got %0d want 0", wait_cnt); end
    total++; if (dbus.req.valid !== 1'b1) begin bad++; $display("FAIL rmid_new_valid: got %0b want 1", dbus.req.valid); end
    total++; if (dbus.req.addr !== 64'h3000) begin bad++; $display("FAIL rmid_new_addr: got %h want 3000", dbus.req.addr); end
    tick();
    idle_inputs();
  endtask

  task automatic test_saturate();
    force dut.wait_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.wait_cnt_q;
    #1;
    total++; if (wait_cnt !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sat_preload: got %h want fffffffe", wait_cnt); end
    mbus.req = '{valid: 1'b1, addr: 64'h6000, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    tick();
    mbus.req.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dbus.resp = '{addr_ok: 1'b0, data_ok: (i == 2), data: 64'h1};
      adv = (i == 2);
      #1;
      total++; if (wait_cnt !== ((i == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF)) begin bad++; $display("FAIL sat_cnt_%0d: got %h", i, wait_cnt); end
      total++; if (dut.state_q !== T_REQ) begin bad++; $display("FAIL sat_state_%0d: got %0d want %0d", i, dut.state_q, T_REQ); end
      tick();
    end
    idle_inputs();
    #1;
    total++; if (wait_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_final: got %h want ffffffff", wait_cnt); end
    total++; if (dut.state_q !== T_IDLE) begin bad++; $display("FAIL sat_exit_state: got %0d want %0d", dut.state_q, T_IDLE); end
    tick();
    total++; if (wait_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold: got %h want ffffffff", wait_cnt); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_hit_stall();
    test_store();
    test_flush();
    test_idle_flush();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
